// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl
// Frames a sample stream for a single-path-delay-feedback FFT core.
// IDLE waits for the first sample; STREAM issues N samples, one per cycle,
// zero-filling any missing ones; FLUSH feeds zeros to drain the delay lines;
// END pulses end16; DRAIN holds off until the output window has closed.
// A latency counter started with start16 opens an N-cycle out_valid window.
//
// Handshake: a sample is taken on a rising clk edge when in_valid and
// in_ready are both high; in_ready depends only on the registered state,
// never on in_valid.
//
// Optional build macro FFT_FRAME_CTRL_BITREV_IDX_EN: when defined, out_idx
// shows the bit-reversed output count (natural-order bin of the SDF output);
// otherwise out_idx is the plain sequential count.

module fft_frame_ctrl #(
   parameter int N       = 16,
   parameter int FLUSH   = 16,
   parameter int LATENCY = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_real,
   input  logic [31:0]            in_img,
   output logic                   start16,
   output logic                   end16,
   output logic [31:0]            A_real,
   output logic [31:0]            A_img,
   output logic                   out_valid,
   output logic [$clog2(N)-1:0]   out_idx,
   output logic [15:0]            frame_cnt,
   output logic                   underrun
);

   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
   localparam logic [15:0]   FL_LAST  = 16'(FLUSH - 1);
   localparam logic [15:0]   LAT_LAST = 16'(LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_STREAM = 3'd1,
      S_FLUSH  = 3'd2,
      S_END    = 3'd3,
      S_DRAIN  = 3'd4
   } state_t;

   state_t          state;
   logic [IW-1:0]   smp_cnt;
   logic [15:0]     flush_cnt;
   logic [15:0]     lat_cnt;
   logic            lat_run;
   logic [IW-1:0]   seq;
   logic            frame_start;

   // Samples are accepted only while idle or streaming.
   assign in_ready    = (state == S_IDLE) || (state == S_STREAM);
   assign frame_start = (state == S_IDLE) && in_valid;

   // Frame sequencer: drives the sample register, the start/end pulses,
   // the completed-frame counter and the sticky underrun flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         start16   <= 1'b0;
         end16     <= 1'b0;
         A_real    <= '0;
         A_img     <= '0;
         frame_cnt <= '0;
         underrun  <= 1'b0;
         smp_cnt   <= '0;
         flush_cnt <= '0;
      end else begin
         start16 <= 1'b0;
         end16   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  A_real  <= in_real;
                  A_img   <= in_img;
                  start16 <= 1'b1;
                  smp_cnt <= IW'(1);
                  state   <= S_STREAM;
               end
            end
            S_STREAM: begin
               // A missing sample still occupies its slot as a zero.
               if (in_valid) begin
                  A_real <= in_real;
                  A_img  <= in_img;
               end else begin
                  A_real   <= '0;
                  A_img    <= '0;
                  underrun <= 1'b1;
               end
               if (smp_cnt == IDX_LAST) begin
                  smp_cnt <= '0;
                  state   <= S_FLUSH;
               end else begin
                  smp_cnt <= smp_cnt + IW'(1);
               end
            end
            S_FLUSH: begin
               A_real <= '0;
               A_img  <= '0;
               if (flush_cnt == FL_LAST) begin
                  flush_cnt <= '0;
                  state     <= S_END;
               end else begin
                  flush_cnt <= flush_cnt + 16'd1;
               end
            end
            S_END: begin
               A_real    <= '0;
               A_img     <= '0;
               end16     <= 1'b1;
               frame_cnt <= frame_cnt + 16'd1;
               state     <= S_DRAIN;
            end
            S_DRAIN: begin
               // Next frame may only start once the output window is over.
               if (!lat_run) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Output window: count LATENCY cycles from the start16 cycle, then hold
   // out_valid for N cycles while the sequential index runs 0..N-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_run   <= 1'b0;
         lat_cnt   <= '0;
         out_valid <= 1'b0;
         seq       <= '0;
      end else begin
         if (lat_run && !out_valid) begin
            if (lat_cnt == LAT_LAST) begin
               out_valid <= 1'b1;
            end else begin
               lat_cnt <= lat_cnt + 16'd1;
            end
         end
         if (out_valid) begin
            if (seq == IDX_LAST) begin
               out_valid <= 1'b0;
               seq       <= '0;
               lat_run   <= 1'b0;
            end else begin
               seq <= seq + IW'(1);
            end
         end
         if (frame_start) begin
            lat_run <= 1'b1;
            lat_cnt <= '0;
         end
      end
   end

`ifdef FFT_FRAME_CTRL_BITREV_IDX_EN
   function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] v);
      logic [IW-1:0] r;
      for (int i = 0; i < IW; i++) begin
         r[i] = v[IW-1-i];
      end
      return r;
   endfunction

   // seq is zero outside the window, and bit-reversed zero is zero.
   assign out_idx = bitrev(seq);
`else
   assign out_idx = seq;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl
// Directed bench for fft_frame_ctrl with default parameters (N=16,
// FLUSH=16, LATENCY=24). Cycle 0 is the first cycle after reset release,
// in which the first sample is offered. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.

module tb_fft_frame_ctrl;

   localparam int N = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_real = '0;
   logic [31:0] in_img = '0;
   logic        start16;
   logic        end16;
   logic [31:0] A_real;
   logic [31:0] A_img;
   logic        out_valid;
   logic [3:0]  out_idx;
   logic [15:0] frame_cnt;
   logic        underrun;

   int n_checks = 0;
   int n_errors = 0;
   int exp_idx[16];

   fft_frame_ctrl #(.N(16), .FLUSH(16), .LATENCY(24)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_real   (in_real),
      .in_img    (in_img),
      .start16   (start16),
      .end16     (end16),
      .A_real    (A_real),
      .A_img     (A_img),
      .out_valid (out_valid),
      .out_idx   (out_idx),
      .frame_cnt (frame_cnt),
      .underrun  (underrun)
   );

   // Clock: 10 time-unit period.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_values(input string where);
      check({where, " start16"},   32'(start16),   32'd0);
      check({where, " end16"},     32'(end16),     32'd0);
      check({where, " A_real"},    A_real,         32'd0);
      check({where, " A_img"},     A_img,          32'd0);
      check({where, " out_valid"}, 32'(out_valid), 32'd0);
      check({where, " out_idx"},   32'(out_idx),   32'd0);
      check({where, " frame_cnt"}, 32'(frame_cnt), 32'd0);
      check({where, " underrun"},  32'(underrun),  32'd0);
   endtask

   // Hold reset for two edges, check reset values, release; returns at cycle 0.
   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      in_real  = '0;
      in_img   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_values("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Runs nf back-to-back frames. Earlier frames keep in_valid high through
   // FLUSH/END/DRAIN to show the controller refuses overlap. The last frame
   // drops sample 'skip' (skip < 0: none). Each frame occupies 42 cycles:
   // handshake at 0, start16 at 1, end16 at 33, window 25..40, IDLE at 42.
   task automatic run_frames(input int nf, input int skip, input logic [15:0] base);
      int total;
      total = 42 * (nf - 1) + 46;
      for (int c = 0; c < total; c++) begin
         int f;
         int r;
         logic [31:0] ea;
         logic [31:0] ei;
         logic        ev;
         logic        eu;
         logic [15:0] ef;
         f = c / 42;
         if (f > nf - 1) f = nf - 1;
         r = c - 42 * f;
         if (f < nf - 1) in_valid = 1'b1;
         else            in_valid = (r < 16) && (r != skip);
         in_real = (r < 16) ? 32'(r) : 32'hA5A5_0000;
         in_img  = '0;

         if (r >= 1 && r <= 16 && !(f == nf - 1 && r - 1 == skip)) ea = 32'(r - 1);
         else                                                        ea = 32'd0;
         ev = (r >= 25) && (r <= 40);
         ei = ev ? 32'(exp_idx[r - 25]) : 32'd0;
         eu = (skip >= 0) && (c >= 42 * (nf - 1) + skip + 1);
         ef = base + 16'(f) + ((r >= 33) ? 16'd1 : 16'd0);

         @(negedge clk);
         check($sformatf("in_ready@%0d", c),  32'(in_ready),  32'((r <= 15) || (r >= 42)));
         check($sformatf("start16@%0d", c),   32'(start16),   32'(r == 1));
         check($sformatf("end16@%0d", c),     32'(end16),     32'(r == 33));
         check($sformatf("A_real@%0d", c),    A_real,         ea);
         check($sformatf("A_img@%0d", c),     A_img,          32'd0);
         check($sformatf("out_valid@%0d", c), 32'(out_valid), 32'(ev));
         check($sformatf("out_idx@%0d", c),   32'(out_idx),   ei);
         check($sformatf("underrun@%0d", c),  32'(underrun),  32'(eu));
         check($sformatf("frame_cnt@%0d", c), 32'(frame_cnt), 32'(ef));
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   // Start a frame, assert rst on the 8th STREAM cycle, then watch for any
   // leftover activity.
   task automatic run_abort();
      for (int c = 0; c <= 8; c++) begin
         in_valid = (c < 8);
         in_real  = 32'(c);
         in_img   = '0;
         if (c == 8) rst = 1'b1;
         @(negedge clk);
         if (c >= 1) begin
            check($sformatf("abort A_real@%0d", c), A_real, 32'(c - 1));
            check($sformatf("abort start16@%0d", c), 32'(start16), 32'(c == 1));
         end
         @(posedge clk);
         #1;
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      for (int c = 9; c <= 50; c++) begin
         @(negedge clk);
         if (c == 9) begin
            check_reset_values("after abort");
            check("after abort in_ready", 32'(in_ready), 32'd1);
         end
         check($sformatf("abort end16@%0d", c),     32'(end16),     32'd0);
         check($sformatf("abort out_valid@%0d", c), 32'(out_valid), 32'd0);
         check($sformatf("abort start16@%0d", c),   32'(start16),   32'd0);
         check($sformatf("abort frame_cnt@%0d", c), 32'(frame_cnt), 32'd0);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
`ifdef FFT_FRAME_CTRL_BITREV_IDX_EN
      exp_idx = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`else
      exp_idx = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif

      // Single clean frame.
      do_reset();
      run_frames(1, -1, 16'h0000);

      // Fifth sample missing: zero slot, sticky underrun, frame completes.
      do_reset();
      run_frames(1, 4, 16'h0000);

      // Second frame offered immediately: held off until DRAIN exits.
      do_reset();
      run_frames(2, -1, 16'h0000);

      // Reset in the middle of a frame.
      do_reset();
      run_abort();

      // frame_cnt wraps from 0xFFFF to 0x0000.
      do_reset();
      force dut.frame_cnt = 16'hFFFF;
      @(posedge clk);
      #1;
      release dut.frame_cnt;
      run_frames(1, -1, 16'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter N, default 16: samples per frame; power of two, 4..64.
REQ-002 SHALL have parameter FLUSH, default 16: zero-sample cycles fed after each frame to drain the delay lines.
REQ-003 SHALL have parameter LATENCY, default 24: cycles from the start16 pulse to the first valid FFT result.
REQ-004 Ports:
  clk  in  1  sole clock, rising edge
  rst  in  1  synchronous, active-high reset
  in_valid  in  1  source sample valid
  in_ready  out  1  controller accepts a sample this cycle
  in_real  in  32  source sample, real part
  in_img  in  32  source sample, imaginary part
  start16  out  1  one-cycle frame-start pulse to the FFT
  end16  out  1  one-cycle frame-end pulse to the FFT
  A_real  out  32  registered sample to the FFT
  A_img  out  32  registered sample to the FFT
  out_valid  out  1  FFT output window active
  out_idx  out  log2(N)  index of the current output sample
  frame_cnt  out  16  completed frames, wraps modulo 2^16
  underrun  out  1  sticky flag: a sample was missing mid-frame
REQ-005 One clock; reset is synchronous and active-high.

Function
REQ-006 States SHALL be IDLE, STREAM, FLUSH, END and DRAIN, encoded in 3 bits.
REQ-007 IDLE: in_ready=1; a handshake (in_valid & in_ready) SHALL register the sample to A_*, pulse start16 in the same cycle A_* updates, set sample count to 1 and go to STREAM.
REQ-008 STREAM: in_ready=1; exactly one sample per cycle SHALL be issued to A_*.
REQ-009 STREAM: if in_valid=0, A_* SHALL be 0, the sample count SHALL still advance and underrun SHALL set.
REQ-010 STREAM: after the N-th issued sample the state SHALL go to FLUSH.
REQ-011 FLUSH: in_ready=0; A_*=0 for exactly FLUSH cycles, then go to END.
REQ-012 END: end16 SHALL pulse for one cycle, in_ready=0; frame_cnt SHALL increment in the same cycle; next state DRAIN.
REQ-013 DRAIN: in_ready=0; SHALL wait until the output window has closed, then return to IDLE. No frame overlap is permitted.
REQ-014 Output latency counter SHALL start at the start16 cycle; out_valid SHALL assert exactly LATENCY cycles later, stay high for N consecutive cycles, then drop.
REQ-015 out_idx SHALL be 0..N-1 during the output window, incrementing by 1 per cycle; it SHALL be 0 when out_valid=0.
REQ-016 A_* SHALL hold its last value in IDLE and DRAIN.
REQ-017 start16 and end16 SHALL never be high in the same cycle, and each SHALL be high for at most one cycle per frame.
REQ-018 frame_cnt SHALL wrap from 0xFFFF to 0x0000 without side effects.
REQ-019 underrun SHALL clear only on rst.

Reset
REQ-020 On rst=1 at a clock edge the following SHALL take these values:
  state = IDLE
  start16 = 0, end16 = 0
  A_* = 0
  out_valid = 0, out_idx = 0
  frame_cnt = 0, underrun = 0
  all counters = 0
  in_ready = 1 from the first cycle after rst deasserts
REQ-021 rst asserted mid-frame SHALL abort the frame: no end16 pulse, no frame_cnt increment, any pending out_valid window cancelled.

Configuration
REQ-022 Macro FFT_FRAME_CTRL_BITREV_IDX_EN:
  defined: out_idx SHALL present the bit-reversed count (log2(N) bits), matching the natural-order bin of the SDF output.
  undefined: out_idx SHALL be the plain sequential count.
  All other behaviour is identical in both cases.

Verification
REQ-023 Reset, then in_valid=1 continuously with samples k=0..15 (real=k, img=0):
  start16 high at cycle 1; A_real = 0..15 on cycles 1..16;
  16 zero samples; end16 at cycle 33;
  out_valid on cycles 25..40; frame_cnt = 1.
REQ-024 Same stream with in_valid=0 for the 5th sample:
  A_real = 0 on that cycle; underrun = 1 and stays 1;
  frame still completes with 16 samples; frame_cnt = 1.
REQ-025 Second frame offered immediately after the first:
  in_ready = 0 until DRAIN exits;
  second start16 only after the first out_valid window closes;
  frame_cnt = 2.
REQ-026 rst pulsed on the 8th STREAM cycle:
  all outputs return to reset values next cycle;
  no end16; no out_valid window.
REQ-027 With FFT_FRAME_CTRL_BITREV_IDX_EN defined, N=16:
  out_idx sequence = 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
  Without the macro: out_idx = 0..15.
REQ-028 frame_cnt preloaded via force to 0xFFFF, one frame run: frame_cnt = 0x0000.
